pn_word_gen: RTL and testbench
==============================

Name: pn_word_gen

Overview:
- Upstream source stage for the PN serializer.
- Generates pseudo-noise words from a Galois LFSR and presents each one as a word plus its bit length (rnd_o / rnd_len_o) with a valid flag.
- Holds each word until the serializer acknowledges it, then advances the LFSR by exactly the number of bits consumed before presenting the next word.
- Result: the concatenated serial stream is a contiguous PN sequence with no reused bits.

Parameters:
- WIDTH, 32, LFSR and word width.
- LEN_W, 5, width of length fields.
- POLY, 32'h80200003, right-shift Galois feedback mask (x^32+x^22+x^2+x+1).
- SEED, 32'h00000001, reset LFSR value and substitute for an all-zero seed; must be non-zero.
- CNT_W, 16, width of the issued-word counter.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-low reset.
- en_i  input  1  run enable.
- seed_ld_i  input  1  load seed_i into the LFSR; honoured in IDLE only.
- seed_i  input  WIDTH  seed value.
- len_i  input  LEN_W  requested word length; 0 means 32 bits.
- ack_i  input  1  serializer has consumed the presented word.
- rnd_o  output  WIDTH  presented word, LSB-aligned, bits above length forced to 0.
- rnd_len_o  output  LEN_W  length of rnd_o, in serializer encoding.
- vld_o  output  1  rnd_o/rnd_len_o valid.
- cnt_o  output  CNT_W  number of words acknowledged.

Behaviour:
- Reset (rst_i=0 at an edge):
  - lfsr=SEED; rnd_o=0; rnd_len_o=0; vld_o=0; cnt_o=0; step counter=0; state=IDLE.
  - Applies from any state, mid-word included; no partial word survives.
- LFSR step: lfsr <= lfsr[0] ? (lfsr>>1) ^ POLY : (lfsr>>1).
- Length L = (len_i==0) ? 32 : len_i. mask = (1<<L)-1; all ones when L=32.
- States: IDLE, LOAD, PRESENT, ADVANCE.
- IDLE:
  - vld_o=0.
  - If seed_ld_i: lfsr <= (seed_i==0) ? SEED : seed_i. seed_ld_i has priority over en_i in the same cycle; stay in IDLE.
  - Else if en_i: go to LOAD.
- LOAD:
  - One cycle.
  - rnd_o <= lfsr & mask; rnd_len_o <= len_i; latch L into step counter; vld_o <= 1; go to PRESENT.
  - len_i is sampled only here.
- PRESENT:
  - rnd_o, rnd_len_o and vld_o held stable.
  - en_i falling does not withdraw the word.
  - On ack_i: vld_o <= 0; cnt_o <= cnt_o+1 (wraps at all ones to 0); go to ADVANCE.
- ADVANCE:
  - One LFSR step per cycle; step counter decrements.
  - After the L-th step: go to LOAD if en_i=1, else IDLE.
  - rnd_o keeps its last value; vld_o=0.
- Latency:
  - en_i sampled in IDLE -> vld_o high after 2 edges.
  - ack_i sampled -> vld_o low next edge, high again L+1 edges later (L steps plus LOAD).
- ack_i outside PRESENT is ignored; no count, no state change.
- seed_ld_i outside IDLE is ignored.
- Lockup: LFSR never becomes zero because a zero seed is substituted and POLY is maximal.

Test Plan:
- Reset: drive rst_i=0 for 2 cycles with en_i=1 and ack_i=1 -> rnd_o=0, rnd_len_o=0, vld_o=0, cnt_o=0 every cycle.
- First word: after reset, len_i=8, en_i=1 -> vld_o=1 two edges later, rnd_o=32'h00000001, rnd_len_o=8; held unchanged for 20 cycles with ack_i=0.
- Advance by length: seed 1, len_i=2, one-cycle ack_i -> vld_o low 3 cycles, then rnd_o=32'h00000002 (lfsr=32'hC0300002), cnt_o=1. Repeat with len_i=1 from seed 1 -> second word 32'h00000001 (lfsr=32'h80200003).
- Full width plus seed: in IDLE, seed_ld_i=1, seed_i=0 -> lfsr=SEED. Then seed_ld_i=1, seed_i=32'hDEADBEEF, then len_i=0 -> rnd_o=32'hDEADBEEF, rnd_len_o=0. After ack -> vld_o low 33 cycles; next word equals a reference-model 32-step advance.
- Handshake edges:
  - ack_i pulsed in IDLE and ADVANCE -> cnt_o unchanged.
  - en_i dropped during PRESENT -> word held until ack, then return to IDLE with vld_o=0.
  - cnt_o preset near 16'hFFFF via 65536 words (or force) -> wraps to 0.
- Reset mid-ADVANCE: rst_i=0 for one cycle at step 3 of 8 -> all outputs at reset values; next word after en_i is 32'h00000001.

Source files
------------

// File: rtl/pn_word_gen.sv
// pn_word_gen: PN word source for the serializer.
// A Galois LFSR supplies words of a requested length. Each word is held until it
// is acknowledged. The LFSR then advances by exactly that many bits, so the
// serial stream formed by all words is one contiguous PN sequence.
module pn_word_gen #(
    parameter int               WIDTH = 32,
    parameter int               LEN_W = 5,
    parameter logic [WIDTH-1:0] POLY  = 32'h80200003,
    parameter logic [WIDTH-1:0] SEED  = 32'h00000001,
    parameter int               CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             seed_ld_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             ack_i,
    output logic [WIDTH-1:0] rnd_o,
    output logic [LEN_W-1:0] rnd_len_o,
    output logic             vld_o,
    output logic [CNT_W-1:0] cnt_o
);

    // One extra bit so the step counter can hold the full-width length.
    localparam int STEP_W = LEN_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PRESENT,
        S_ADVANCE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_lfsr;
    logic [WIDTH-1:0]  w_lfsr_step;
    logic [WIDTH-1:0]  w_mask;
    logic [WIDTH-1:0]  r_rnd;
    logic [LEN_W-1:0]  r_len;
    logic [STEP_W-1:0] w_len;
    logic [STEP_W-1:0] r_step;
    logic              r_vld;
    logic [CNT_W-1:0]  r_cnt;

    // A requested length of 0 encodes the full word width.
    assign w_len = (len_i == '0) ? STEP_W'(WIDTH) : STEP_W'(len_i);

    // One right-shift Galois LFSR step.
    assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ POLY) : (r_lfsr >> 1);

    // Mask with the low L bits set.
    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i < 32'(w_len)) begin
                w_mask[i] = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. In IDLE, a seed load takes priority over starting a word.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!seed_ld_i && en_i) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_PRESENT;
            end
            S_PRESENT: begin
                if (ack_i) begin
                    w_state_nxt = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (r_step == STEP_W'(1)) begin
                    w_state_nxt = en_i ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: LFSR, presented word, step counter, valid flag, issue count.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_lfsr <= SEED;
            r_rnd  <= '0;
            r_len  <= '0;
            r_step <= '0;
            r_vld  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_vld <= 1'b0;
                    if (seed_ld_i) begin
                        r_lfsr <= (seed_i == '0) ? SEED : seed_i;
                    end
                end
                S_LOAD: begin
                    r_rnd  <= r_lfsr & w_mask;
                    r_len  <= len_i;
                    r_step <= w_len;
                    r_vld  <= 1'b1;
                end
                S_PRESENT: begin
                    if (ack_i) begin
                        r_vld <= 1'b0;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_ADVANCE: begin
                    r_vld  <= 1'b0;
                    r_lfsr <= w_lfsr_step;
                    r_step <= r_step - STEP_W'(1);
                end
                default: begin
                    r_vld <= 1'b0;
                end
            endcase
        end
    end

    assign rnd_o     = r_rnd;
    assign rnd_len_o = r_len;
    assign vld_o     = r_vld;
    assign cnt_o     = r_cnt;

endmodule

// File: tb/tb_pn_word_gen.sv
// Testbench for pn_word_gen.
// The reference model tracks the LFSR value at the start of the next word and
// advances it by whole word lengths with a multi-step function.
module tb_pn_word_gen;

    localparam logic [31:0] POLY = 32'h80200003;
    localparam logic [31:0] SEED = 32'h00000001;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        en_i = 1'b0;
    logic        seed_ld_i = 1'b0;
    logic [31:0] seed_i = '0;
    logic [4:0]  len_i = '0;
    logic        ack_i = 1'b0;
    logic [31:0] rnd_o;
    logic [4:0]  rnd_len_o;
    logic        vld_o;
    logic [15:0] cnt_o;

    logic [31:0] rnd_w;
    logic [4:0]  len_w;
    logic        vld_w;
    logic [3:0]  cnt_w;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] model;

    pn_word_gen dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .seed_ld_i(seed_ld_i),
        .seed_i(seed_i), .len_i(len_i), .ack_i(ack_i), .rnd_o(rnd_o),
        .rnd_len_o(rnd_len_o), .vld_o(vld_o), .cnt_o(cnt_o)
    );

    // Narrow-counter instance so counter wrap is reachable in a short run.
    pn_word_gen #(.CNT_W(4)) dut_w (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .seed_ld_i(seed_ld_i),
        .seed_i(seed_i), .len_i(len_i), .ack_i(ack_i), .rnd_o(rnd_w),
        .rnd_len_o(len_w), .vld_o(vld_w), .cnt_o(cnt_w)
    );

    always #5 clk_i = ~clk_i;

    // Advance an LFSR value by n bits of the PN sequence.
    function automatic logic [31:0] adv(input logic [31:0] v, input int unsigned n);
        logic [31:0] x;
        x = v;
        for (int unsigned k = 0; k < n; k++) begin
            x = x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
        end
        return x;
    endfunction

    function automatic int unsigned len_of(input logic [4:0] l);
        return (l == 5'd0) ? 32 : int'(l);
    endfunction

    function automatic logic [31:0] mask_of(input int unsigned n);
        if (n >= 32) return 32'hFFFFFFFF;
        return (32'd1 << n) - 32'd1;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_i = 1'b0; en_i = 1'b0; ack_i = 1'b0; seed_ld_i = 1'b0;
        tick();
        rst_i = 1'b1;
        model = SEED;
    endtask

    task automatic wait_vld(input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned c = 0; c < budget; c++) begin
            tick();
            if (vld_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0; en_i = 1'b1; ack_i = 1'b1; len_i = 5'd8;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_vec++;
            if ({rnd_o, rnd_len_o, vld_o, cnt_o} !== 54'h0) begin
                n_err++;
                $display("FAIL reset: rnd=%h len=%0d vld=%b cnt=%0d, want all zero",
                         rnd_o, rnd_len_o, vld_o, cnt_o);
            end
        end
        rst_i = 1'b1; en_i = 1'b0; ack_i = 1'b0;
        model = SEED;
    endtask

    task automatic test_first_word();
        len_i = 5'd8; en_i = 1'b1;
        tick();
        n_vec++;
        if (vld_o !== 1'b0) begin
            n_err++; $display("FAIL first_lat1: vld=%b want 0", vld_o);
        end
        tick();
        n_vec++;
        if (vld_o !== 1'b1 || rnd_o !== 32'h00000001 || rnd_len_o !== 5'd8) begin
            n_err++;
            $display("FAIL first_word: vld=%b rnd=%h len=%0d want 1/00000001/8", vld_o, rnd_o, rnd_len_o);
        end
        en_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_vec++;
            if (vld_o !== 1'b1 || rnd_o !== 32'h00000001 || rnd_len_o !== 5'd8 || cnt_o !== 16'd0) begin
                n_err++;
                $display("FAIL first_hold: vld=%b rnd=%h len=%0d cnt=%0d want 1/00000001/8/0",
                         vld_o, rnd_o, rnd_len_o, cnt_o);
            end
        end
    endtask

    task automatic test_advance();
        logic [4:0]  lens [2] = '{5'd2, 5'd1};
        logic [31:0] exp2 [2] = '{32'h00000002, 32'h00000001};
        bit ok;
        for (int t = 0; t < 2; t++) begin
            apply_reset();
            len_i = lens[t]; en_i = 1'b1;
            wait_vld(4, ok);
            n_vec++;
            if (!ok || rnd_o !== 32'h00000001) begin
                n_err++; $display("FAIL adv_first%0d: ok=%b rnd=%h want 00000001", t, ok, rnd_o);
            end
            ack_i = 1'b1;
            tick();
            ack_i = 1'b0;
            model = adv(model, len_of(lens[t]));
            for (int unsigned c = 0; c <= len_of(lens[t]); c++) begin
                if (c != 0) tick();
                n_vec++;
                if (vld_o !== 1'b0) begin
                    n_err++; $display("FAIL adv_gap%0d_%0d: vld=%b want 0", t, c, vld_o);
                end
            end
            tick();
            n_vec++;
            if (vld_o !== 1'b1 || rnd_o !== exp2[t] || cnt_o !== 16'd1) begin
                n_err++;
                $display("FAIL adv_second%0d: vld=%b rnd=%h cnt=%0d want 1/%h/1", t, vld_o, rnd_o, cnt_o, exp2[t]);
            end
            n_vec++;
            if (rnd_o !== (model & mask_of(len_of(lens[t])))) begin
                n_err++; $display("FAIL adv_model%0d: rnd=%h want %h", t, rnd_o, model & mask_of(len_of(lens[t])));
            end
        end
    endtask

    task automatic test_full_seed();
        bit ok;
        apply_reset();
        seed_ld_i = 1'b1; seed_i = 32'h0;
        tick();
        seed_ld_i = 1'b0; len_i = 5'd0; en_i = 1'b1;
        wait_vld(4, ok);
        n_vec++;
        if (!ok || rnd_o !== SEED || rnd_len_o !== 5'd0) begin
            n_err++; $display("FAIL zero_seed: ok=%b rnd=%h len=%0d want %h/0", ok, rnd_o, rnd_len_o, SEED);
        end
        en_i = 1'b0; ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        repeat (34) tick();
        n_vec++;
        if (vld_o !== 1'b0 || rnd_o !== SEED) begin
            n_err++; $display("FAIL idle_hold: vld=%b rnd=%h want 0/%h", vld_o, rnd_o, SEED);
        end
        seed_ld_i = 1'b1; seed_i = 32'hDEADBEEF; en_i = 1'b1;
        tick();
        seed_ld_i = 1'b0;
        tick();
        n_vec++;
        if (vld_o !== 1'b0) begin
            n_err++; $display("FAIL seed_priority: vld=%b want 0", vld_o);
        end
        tick();
        n_vec++;
        if (vld_o !== 1'b1 || rnd_o !== 32'hDEADBEEF || rnd_len_o !== 5'd0) begin
            n_err++; $display("FAIL seed_word: vld=%b rnd=%h len=%0d want 1/deadbeef/0", vld_o, rnd_o, rnd_len_o);
        end
        model = 32'hDEADBEEF;
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        model = adv(model, 32);
        for (int c = 0; c < 33; c++) begin
            if (c != 0) tick();
            n_vec++;
            if (vld_o !== 1'b0) begin
                n_err++; $display("FAIL full_gap%0d: vld=%b want 0", c, vld_o);
            end
        end
        tick();
        n_vec++;
        if (vld_o !== 1'b1 || rnd_o !== model || cnt_o !== 16'd2) begin
            n_err++; $display("FAIL full_next: vld=%b rnd=%h cnt=%0d want 1/%h/2", vld_o, rnd_o, cnt_o, model);
        end
    endtask

    task automatic test_handshake();
        bit ok;
        logic [31:0] held;
        apply_reset();
        ack_i = 1'b1;
        repeat (3) tick();
        ack_i = 1'b0;
        n_vec++;
        if (cnt_o !== 16'd0 || vld_o !== 1'b0) begin
            n_err++; $display("FAIL ack_idle: cnt=%0d vld=%b want 0/0", cnt_o, vld_o);
        end
        len_i = 5'd8; en_i = 1'b1;
        wait_vld(4, ok);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        model = adv(model, 8);
        tick();
        ack_i = 1'b1;
        repeat (3) tick();
        ack_i = 1'b0;
        n_vec++;
        if (cnt_o !== 16'd1 || vld_o !== 1'b0) begin
            n_err++; $display("FAIL ack_advance: cnt=%0d vld=%b want 1/0", cnt_o, vld_o);
        end
        wait_vld(10, ok);
        n_vec++;
        if (!ok || rnd_o !== (model & mask_of(8)) || cnt_o !== 16'd1) begin
            n_err++; $display("FAIL after_adv_ack: ok=%b rnd=%h cnt=%0d want %h/1", ok, rnd_o, cnt_o, model & mask_of(8));
        end
        held = rnd_o;
        en_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_vec++;
            if (vld_o !== 1'b1 || rnd_o !== held) begin
                n_err++; $display("FAIL en_drop_hold%0d: vld=%b rnd=%h want 1/%h", c, vld_o, rnd_o, held);
            end
        end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        model = adv(model, 8);
        n_vec++;
        if (cnt_o !== 16'd2) begin
            n_err++; $display("FAIL en_drop_cnt: cnt=%0d want 2", cnt_o);
        end
        for (int c = 0; c < 12; c++) begin
            tick();
            n_vec++;
            if (vld_o !== 1'b0 || rnd_o !== held) begin
                n_err++; $display("FAIL en_drop_idle%0d: vld=%b rnd=%h want 0/%h", c, vld_o, rnd_o, held);
            end
        end
        len_i = 5'd3; en_i = 1'b1;
        wait_vld(4, ok);
        n_vec++;
        if (!ok || rnd_o !== (model & mask_of(3)) || rnd_len_o !== 5'd3) begin
            n_err++; $display("FAIL restart: ok=%b rnd=%h len=%0d want %h/3", ok, rnd_o, rnd_len_o, model & mask_of(3));
        end
    endtask

    task automatic test_wrap();
        bit ok;
        apply_reset();
        len_i = 5'd1; en_i = 1'b1;
        for (int unsigned k = 1; k <= 18; k++) begin
            wait_vld(4, ok);
            n_vec++;
            if (!ok || rnd_o !== (model & 32'h1) || vld_w !== 1'b1 || rnd_w !== (model & 32'h1) || len_w !== 5'd1) begin
                n_err++;
                $display("FAIL wrap_word%0d: ok=%b rnd=%h rnd_w=%h vld_w=%b len_w=%0d want %h", k, ok, rnd_o, rnd_w, vld_w, len_w, model & 32'h1);
            end
            ack_i = 1'b1;
            tick();
            ack_i = 1'b0;
            model = adv(model, 1);
            n_vec++;
            if (cnt_o !== 16'(k) || cnt_w !== 4'(k % 16)) begin
                n_err++; $display("FAIL wrap_cnt%0d: cnt=%0d cnt_w=%0d want %0d/%0d", k, cnt_o, cnt_w, k, k % 16);
            end
        end
    endtask

    task automatic test_reset_mid_advance();
        bit ok;
        apply_reset();
        len_i = 5'd8; en_i = 1'b1;
        wait_vld(4, ok);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        repeat (2) tick();
        rst_i = 1'b0; en_i = 1'b0;
        tick();
        n_vec++;
        if ({rnd_o, rnd_len_o, vld_o, cnt_o} !== 54'h0) begin
            n_err++; $display("FAIL mid_reset: rnd=%h len=%0d vld=%b cnt=%0d want all zero", rnd_o, rnd_len_o, vld_o, cnt_o);
        end
        rst_i = 1'b1;
        model = SEED;
        tick();
        n_vec++;
        if (vld_o !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_idle: vld=%b want 0", vld_o);
        end
        en_i = 1'b1;
        wait_vld(4, ok);
        n_vec++;
        if (!ok || rnd_o !== 32'h00000001 || rnd_len_o !== 5'd8) begin
            n_err++; $display("FAIL mid_reset_word: ok=%b rnd=%h len=%0d want 00000001/8", ok, rnd_o, rnd_len_o);
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [31:0] s;
        logic [4:0]  cur_len;
        apply_reset();
        s = $urandom;
        if (s == 32'h0) s = 32'h1;
        seed_ld_i = 1'b1; seed_i = s;
        tick();
        seed_ld_i = 1'b0;
        model = s;
        cur_len = 5'($urandom_range(0, 31));
        len_i = cur_len; en_i = 1'b1;
        for (int unsigned k = 0; k < 40; k++) begin
            wait_vld(40, ok);
            n_vec++;
            if (!ok || rnd_o !== (model & mask_of(len_of(cur_len))) || rnd_len_o !== cur_len || cnt_o !== 16'(k)) begin
                n_err++;
                $display("FAIL rand_word%0d: ok=%b rnd=%h len=%0d cnt=%0d want %h/%0d/%0d",
                         k, ok, rnd_o, rnd_len_o, cnt_o, model & mask_of(len_of(cur_len)), cur_len, k);
            end
            repeat ($urandom_range(0, 3)) begin
                en_i = 1'($urandom_range(0, 1));
                tick();
            end
            model = adv(model, len_of(cur_len));
            cur_len = 5'($urandom_range(0, 31));
            len_i = cur_len;
            ack_i = 1'b1;
            tick();
            ack_i = 1'b0;
            en_i = 1'b1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_word();
        test_advance();
        test_full_seed();
        test_handshake();
        test_wrap();
        test_reset_mid_advance();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
